io_port_controller: RTL and testbench
=====================================

Name: io_port_controller

Overview:
Peripheral at the far end of the CPU's port and interrupt interface, instantiated beside phase_3 in the system top. It buffers words from an external producer, presents them on the CPU input port, and raises an interrupt pulse for the CPU's interrupt_hold. It also captures OUT-instruction writes from the CPU and drains them to an external consumer.
phase_3 exports the OUT strobe and the IN-read strobe for this block.

Parameters:
DATA_WIDTH, 16, port word width (matches CPU 16-bit ports)
RX_DEPTH, 4, inbound FIFO entries (power of 2, >=2)
TX_DEPTH, 4, outbound FIFO entries (power of 2, >=2)
HOLDOFF_CYCLES, 2, minimum idle cycles after an ack before the next interrupt pulse (0 allowed)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_rx_valid  in  1  external producer has a word
i_rx_data  in  DATA_WIDTH  producer word
o_rx_ready  out  1  inbound FIFO can accept
o_input_port  out  DATA_WIDTH  to CPU i_input_port: inbound FIFO head
i_in_ack  in  1  CPU IN-instruction strobe: pops inbound head
o_interrupt  out  1  to CPU i_interrupt: one-cycle pulse
i_out_write  in  1  CPU OUT-instruction strobe
i_out_data  in  DATA_WIDTH  CPU o_output_port value
o_tx_valid  out  1  outbound word available
o_tx_data  out  DATA_WIDTH  outbound FIFO head
i_tx_ready  in  1  external consumer accepts
o_rx_count  out  clog2(RX_DEPTH+1)  inbound occupancy
o_tx_overflow  out  1  sticky: OUT write dropped on full FIFO

Behaviour:
- Reset (async, active-high): both FIFOs empty; FSM in IDLE; holdoff counter 0; o_interrupt=0, o_tx_valid=0, o_tx_overflow=0, o_input_port=0, o_rx_count=0. Reset mid-operation discards all buffered words.
- Inbound: push on i_rx_valid & o_rx_ready. o_rx_ready = !rx_full (combinational). o_input_port = head when non-empty, else 0.
- i_in_ack pops when non-empty. An ack on an empty FIFO is ignored. If push and ack occur on an empty FIFO in the same cycle, the ack is ignored and the push lands. If both occur on a non-empty FIFO, the count is unchanged and the head advances.
- Outbound: i_out_write pushes i_out_data when not full. If full and no pop occurs in the same cycle, the word is dropped and o_tx_overflow is set; it stays set until reset.
- If full with a write and a pop (o_tx_valid & i_tx_ready) in the same cycle, the write is accepted.
- o_tx_valid = !tx_empty. o_tx_data = head. Pop on o_tx_valid & i_tx_ready.
- Pointers wrap modulo depth. Each FIFO keeps an explicit count to separate full from empty.
- Interrupt FSM (registered):
  - IDLE: rx non-empty -> PULSE.
  - PULSE: o_interrupt=1 for exactly this cycle. i_in_ack this cycle -> HOLDOFF, else -> WAIT_ACK.
  - WAIT_ACK: o_interrupt=0. i_in_ack -> HOLDOFF with counter=HOLDOFF_CYCLES; if HOLDOFF_CYCLES=0, go straight to IDLE.
  - HOLDOFF: decrement the counter each cycle; at 0 -> IDLE.
  - o_interrupt is 0 in every state except PULSE.
- Latency: a push at edge N makes rx non-empty in cycle N+1; the FSM is in PULSE in cycle N+2, so o_interrupt is high during N+2.
- One pulse per acked word. Words still queued after an ack re-trigger a pulse after the holdoff.
- External producer and consumer are in the i_clk domain; no CDC inside this block.

Decomposition:
- Shared package io_pkg: FSM state encoding (IDLE, PULSE, WAIT_ACK, HOLDOFF) and a DATA_WIDTH default constant of 16.
- One sub-module, sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count/head), instantiated twice.
- Top level holds the FSM, holdoff counter and overflow flag.

Test Plan:
- Reset: after deasserting i_reset -> o_rx_ready=1, o_interrupt=0, o_tx_valid=0, o_input_port=0, o_rx_count=0.
- Single word: push 0x1234 at edge 0 -> o_input_port=0x1234 in cycle 1, o_interrupt high only in cycle 2. Ack in cycle 4 -> count 0; with HOLDOFF_CYCLES=2, the FSM is back in IDLE in cycle 7 and no further pulse occurs.
- Back-to-back: push 0xA, 0xB, 0xC, 0xD, then attempt 0xE -> o_rx_ready=0 at count 4 and 0xE is not taken. Each ack yields the next head in order A..D with one pulse per word, pulses at least 3 cycles apart.
- Ack on empty: i_in_ack with FIFO empty -> count stays 0, no pulse. Push with simultaneous ack on empty -> count becomes 1.
- Outbound overflow: i_tx_ready=0, write 0x0001..0x0005 -> first 4 held and o_tx_overflow=1 after the 5th. Drain -> 0x0001..0x0004 in order; overflow stays 1.
- Full with write and pop: TX full, write 0x00FF while i_tx_ready=1 -> accepted, o_tx_overflow stays 0, and 0x00FF is drained last.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the CPU port/interrupt peripheral.
package io_pkg;

    // Port word width of the CPU IN/OUT ports.
    localparam int DATA_WIDTH_DEFAULT = 16;

    // Interrupt FSM state encoding.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PULSE    = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
    localparam logic [1:0] ST_HOLDOFF  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an explicit occupancy count and a combinational head.
// The caller qualifies push/pop: push is never issued on full without a pop,
// and pop is never issued on empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [WIDTH-1:0]               head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage write.
    // NOTE: the data array is deliberately not reset; the count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/io_port_controller.sv
// CPU-side port peripheral: buffers producer words for IN reads with an
// interrupt pulse per word, and buffers OUT writes for an external consumer.
module io_port_controller
    import io_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
    parameter int RX_DEPTH       = 4,
    parameter int TX_DEPTH       = 4,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_rx_valid,
    input  logic [DATA_WIDTH-1:0]         i_rx_data,
    output logic                          o_rx_ready,
    output logic [DATA_WIDTH-1:0]         o_input_port,
    input  logic                          i_in_ack,
    output logic                          o_interrupt,
    input  logic                          i_out_write,
    input  logic [DATA_WIDTH-1:0]         i_out_data,
    output logic                          o_tx_valid,
    output logic [DATA_WIDTH-1:0]         o_tx_data,
    input  logic                          i_tx_ready,
    output logic [$clog2(RX_DEPTH+1)-1:0] o_rx_count,
    output logic                          o_tx_overflow
);

    localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

    logic                          rx_full, rx_empty, rx_push, rx_pop;
    logic [DATA_WIDTH-1:0]         rx_head;
    logic                          tx_full, tx_empty, tx_push, tx_pop;
    logic [$clog2(TX_DEPTH+1)-1:0] tx_count_unused;
    logic [1:0]                    state, state_next;
    logic [HW-1:0]                 holdoff_cnt, holdoff_next;

    // An ack on an empty FIFO is ignored, even when a push lands that cycle.
    assign rx_push = i_rx_valid & ~rx_full;
    assign rx_pop  = i_in_ack & ~rx_empty;

    // A full TX FIFO still takes a write when the consumer drains it that cycle.
    assign tx_pop  = ~tx_empty & i_tx_ready;
    assign tx_push = i_out_write & (~tx_full | tx_pop);

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (i_clk),
        .rst       (i_reset),
        .push      (rx_push),
        .push_data (i_rx_data),
        .pop       (rx_pop),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (o_rx_count),
        .head      (rx_head)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (i_clk),
        .rst       (i_reset),
        .push      (tx_push),
        .push_data (i_out_data),
        .pop       (tx_pop),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count_unused),
        .head      (o_tx_data)
    );

    assign o_rx_ready   = ~rx_full;
    assign o_input_port = rx_empty ? '0 : rx_head;
    assign o_tx_valid   = ~tx_empty;
    assign o_interrupt  = (state == ST_PULSE);

    // Interrupt FSM next-state: one pulse per word, then wait for the ack and hold off.
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next   = state;
        holdoff_next = holdoff_cnt;
        case (state)
            ST_IDLE: begin
                if (!rx_empty) begin
                    state_next = ST_PULSE;
                end
            end
            ST_PULSE, ST_WAIT_ACK: begin
                if (rx_pop) begin
                    if (HOLDOFF_CYCLES == 0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next   = ST_HOLDOFF;
                        holdoff_next = HW'(HOLDOFF_CYCLES);
                    end
                end else begin
                    state_next = ST_WAIT_ACK;
                end
            end
            ST_HOLDOFF: begin
                if (holdoff_cnt <= HW'(1)) begin
                    state_next   = ST_IDLE;
                    holdoff_next = '0;
                end else begin
                    holdoff_next = holdoff_cnt - 1'b1;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                holdoff_next = '0;
            end
        endcase
    end

    // Interrupt FSM and holdoff counter registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            holdoff_cnt <= '0;
        end else begin
            state       <= state_next;
            holdoff_cnt <= holdoff_next;
        end
    end

    // Sticky flag for an OUT write dropped on a full FIFO with no drain.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_tx_overflow <= 1'b0;
        end else if (i_out_write && tx_full && !tx_pop) begin
            o_tx_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_port_controller.sv
// Scoreboard bench for io_port_controller: directed stimulus pushes expected
// IN reads and drained OUT words into queues; a negedge monitor compares them.
module tb_io_port_controller;
    import io_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_rx_valid = 1'b0;
    logic [15:0] i_rx_data = '0;
    logic        o_rx_ready;
    logic [15:0] o_input_port;
    logic        i_in_ack = 1'b0;
    logic        o_interrupt;
    logic        i_out_write = 1'b0;
    logic [15:0] i_out_data = '0;
    logic        o_tx_valid;
    logic [15:0] o_tx_data;
    logic        i_tx_ready = 1'b0;
    logic [2:0]  o_rx_count;
    logic        o_tx_overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int irq_count = 0;
    logic irq_prev = 1'b0;
    logic [15:0] rx_q[$];
    logic [15:0] tx_q[$];
    int irq_cycles[$];

    io_port_controller #(
        .DATA_WIDTH(16), .RX_DEPTH(4), .TX_DEPTH(4), .HOLDOFF_CYCLES(2)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_rx_valid    (i_rx_valid),
        .i_rx_data     (i_rx_data),
        .o_rx_ready    (o_rx_ready),
        .o_input_port  (o_input_port),
        .i_in_ack      (i_in_ack),
        .o_interrupt   (o_interrupt),
        .i_out_write   (i_out_write),
        .i_out_data    (i_out_data),
        .o_tx_valid    (o_tx_valid),
        .o_tx_data     (o_tx_data),
        .i_tx_ready    (i_tx_ready),
        .o_rx_count    (o_rx_count),
        .o_tx_overflow (o_tx_overflow)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_irq(input int target);
        int budget = 30;
        while (irq_count < target && budget > 0) begin
            tick();
            budget--;
        end
        check("irq_arrived", 32'(irq_count >= target), 1);
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues.
    always @(negedge i_clk) begin
        if (i_reset) begin
            irq_prev = 1'b0;
        end else begin
            if (o_interrupt) begin
                check("irq_single_cycle", 32'(irq_prev), 0);
                irq_count++;
                irq_cycles.push_back(cyc);
            end
            irq_prev = o_interrupt;
            if (i_in_ack && o_rx_count != 0) begin
                if (rx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx_unexpected: got 0x%0h expected none", o_input_port);
                end else begin
                    check("rx_word", 32'(o_input_port), 32'(rx_q.pop_front()));
                end
            end
            if (o_tx_valid && i_tx_ready) begin
                if (tx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected: got 0x%0h expected none", o_tx_data);
                end else begin
                    check("tx_word", 32'(o_tx_data), 32'(tx_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [15:0] words [4];
        words[0] = 16'h000A; words[1] = 16'h000B; words[2] = 16'h000C; words[3] = 16'h000D;

        // Reset state.
        repeat (3) tick();
        i_reset = 1'b0;
        tick();
        check("reset_rx_ready", 32'(o_rx_ready), 1);
        check("reset_irq", 32'(o_interrupt), 0);
        check("reset_tx_valid", 32'(o_tx_valid), 0);
        check("reset_input_port", 32'(o_input_port), 0);
        check("reset_rx_count", 32'(o_rx_count), 0);
        check("reset_overflow", 32'(o_tx_overflow), 0);

        // Single word: push at edge 0, pulse in cycle 2, ack in cycle 4.
        i_rx_valid = 1'b1; i_rx_data = 16'h1234;
        tick();                                   // cycle 1
        i_rx_valid = 1'b0;
        check("single_head", 32'(o_input_port), 32'h1234);
        check("single_count", 32'(o_rx_count), 1);
        check("single_irq_c1", 32'(o_interrupt), 0);
        tick();                                   // cycle 2
        check("single_irq_c2", 32'(o_interrupt), 1);
        tick();                                   // cycle 3
        check("single_irq_c3", 32'(o_interrupt), 0);
        check("single_state_c3", 32'(dut.state), 32'(ST_WAIT_ACK));
        tick();                                   // cycle 4
        i_in_ack = 1'b1; rx_q.push_back(16'h1234);
        tick();                                   // cycle 5
        i_in_ack = 1'b0;
        check("single_count_after_ack", 32'(o_rx_count), 0);
        check("single_state_c5", 32'(dut.state), 32'(ST_HOLDOFF));
        tick();                                   // cycle 6
        check("single_state_c6", 32'(dut.state), 32'(ST_HOLDOFF));
        tick();                                   // cycle 7
        check("single_state_c7", 32'(dut.state), 32'(ST_IDLE));
        base = irq_count;
        repeat (8) tick();
        check("single_no_extra_irq", 32'(irq_count), 32'(base));

        // Back-to-back fill, rejected fifth word, in-order acks.
        base = irq_count;
        irq_cycles.delete();
        for (int k = 0; k < 4; k++) begin
            i_rx_valid = 1'b1; i_rx_data = words[k];
            tick();
        end
        check("fill_count", 32'(o_rx_count), 4);
        check("fill_ready", 32'(o_rx_ready), 0);
        i_rx_data = 16'h000E;
        tick();
        i_rx_valid = 1'b0;
        check("fill_e_rejected", 32'(o_rx_count), 4);
        for (int k = 0; k < 4; k++) begin
            wait_irq(base + k + 1);
            i_in_ack = 1'b1; rx_q.push_back(words[k]);
            tick();
            i_in_ack = 1'b0;
        end
        repeat (10) tick();
        check("fill_pulse_total", 32'(irq_count), 32'(base + 4));
        check("fill_drained", 32'(o_rx_count), 0);
        for (int k = 1; k < irq_cycles.size(); k++) begin
            check("fill_pulse_spacing", 32'((irq_cycles[k] - irq_cycles[k-1]) >= 3), 1);
        end

        // Ack on empty, then push with simultaneous ack on empty.
        base = irq_count;
        i_in_ack = 1'b1;
        tick();
        i_in_ack = 1'b0;
        repeat (5) tick();
        check("empty_ack_count", 32'(o_rx_count), 0);
        check("empty_ack_no_irq", 32'(irq_count), 32'(base));
        i_rx_valid = 1'b1; i_rx_data = 16'h0055; i_in_ack = 1'b1;
        tick();
        i_rx_valid = 1'b0; i_in_ack = 1'b0;
        check("push_ack_count", 32'(o_rx_count), 1);
        check("push_ack_head", 32'(o_input_port), 32'h0055);
        wait_irq(base + 1);
        i_in_ack = 1'b1; rx_q.push_back(16'h0055);
        tick();
        i_in_ack = 1'b0;
        repeat (6) tick();

        // Outbound overflow with the consumer stalled.
        i_tx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) check("ovf_before_fifth", 32'(o_tx_overflow), 0);
            i_out_write = 1'b1; i_out_data = 16'(k);
            if (k <= 4) tx_q.push_back(16'(k));
            tick();
        end
        i_out_write = 1'b0;
        check("ovf_set", 32'(o_tx_overflow), 1);
        check("ovf_tx_valid", 32'(o_tx_valid), 1);
        check("ovf_head", 32'(o_tx_data), 32'h0001);
        i_tx_ready = 1'b1;
        repeat (4) tick();
        i_tx_ready = 1'b0;
        check("ovf_drained", 32'(o_tx_valid), 0);
        check("ovf_sticky", 32'(o_tx_overflow), 1);

        // Reset mid-operation discards buffered words and clears the flag.
        i_rx_valid = 1'b1; i_rx_data = 16'h0077;
        tick();
        i_rx_valid = 1'b0;
        tick();
        i_reset = 1'b1;
        #1;
        check("midreset_rx_count", 32'(o_rx_count), 0);
        check("midreset_overflow", 32'(o_tx_overflow), 0);
        check("midreset_irq", 32'(o_interrupt), 0);
        check("midreset_input_port", 32'(o_input_port), 0);
        tick();
        i_reset = 1'b0;
        tick();

        // Full TX with a simultaneous write and drain: write accepted.
        for (int k = 0; k < 4; k++) begin
            i_out_write = 1'b1; i_out_data = 16'(16'h0010 + k);
            tx_q.push_back(16'(16'h0010 + k));
            tick();
        end
        i_out_write = 1'b1; i_out_data = 16'h00FF; i_tx_ready = 1'b1;
        tx_q.push_back(16'h00FF);
        tick();
        i_out_write = 1'b0;
        check("fullpop_overflow", 32'(o_tx_overflow), 0);
        repeat (6) tick();
        i_tx_ready = 1'b0;
        check("fullpop_drained", 32'(o_tx_valid), 0);
        check("fullpop_overflow_end", 32'(o_tx_overflow), 0);

        check("rx_queue_empty", 32'(rx_q.size()), 0);
        check("tx_queue_empty", 32'(tx_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
